reorder_buffer: RTL and testbench

Two-wide in-order retirement buffer for the out-of-order core, downstream of the renamer and reservation station. Each renamed instruction is allocated an entry holding its new and superseded physical destination. Functional units mark entries complete by tag. Up to two completed head entries retire per cycle, and their superseded physical registers are returned on `free_reg1`/`free_reg2` to the free-pool merge logic.

---
 rtl/reorder_buffer.sv | 160 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer
//
// Two-wide in-order retirement buffer. Each renamed instruction takes one
// entry holding its new and superseded physical destination. Functional
// units mark entries complete by tag; up to two completed entries at the
// head retire per cycle. The superseded physical registers of the retirees
// are returned to the free pool on free_reg1/free_reg2.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   alloc_valid1/2             allocation requests (slot 2 needs slot 1)
//   alloc1/2_p_rd              new physical destination (0 = none)
//   alloc1/2_p_old_rd          superseded physical register (0 = none)
//   alloc_ready                at least two free entries
//   alloc_tag1/2               tags handed out this cycle (tail, tail+1)
//   wb_valid, wb_tag           per-FU completion strobe and tag
//   flush                      discard every entry
//   free_reg1/2                registered superseded pregs of retirees
//   retire_count               registered number retired (0..2)
//   rob_empty, rob_full        occupancy flags
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int PREG_W = 6,
  parameter int NUM_FU = 3,
  parameter int TAG_W  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alloc_valid1,
  input  logic                    alloc_valid2,
  input  logic [PREG_W-1:0]       alloc1_p_rd,
  input  logic [PREG_W-1:0]       alloc2_p_rd,
  input  logic [PREG_W-1:0]       alloc1_p_old_rd,
  input  logic [PREG_W-1:0]       alloc2_p_old_rd,
  output logic                    alloc_ready,
  output logic [TAG_W-1:0]        alloc_tag1,
  output logic [TAG_W-1:0]        alloc_tag2,
  input  logic [NUM_FU-1:0]       wb_valid,
  input  logic [NUM_FU*TAG_W-1:0] wb_tag,
  input  logic                    flush,
  output logic [PREG_W-1:0]       free_reg1,
  output logic [PREG_W-1:0]       free_reg2,
  output logic [1:0]              retire_count,
  output logic                    rob_empty,
  output logic                    rob_full
);

  localparam int CNT_W = TAG_W + 1;

  // Entry state: control bits are reset, payload is not.
  logic [DEPTH-1:0]             valid_q;
  logic [DEPTH-1:0]             done_q;
  logic [DEPTH-1:0][PREG_W-1:0] p_rd_q;
  logic [DEPTH-1:0][PREG_W-1:0] p_old_q;

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [TAG_W-1:0] head1;
  logic [TAG_W-1:0] tail1;
  logic             alloc1_ok;
  logic             alloc2_ok;
  logic             ret0;
  logic             ret1;
  logic [CNT_W-1:0] alloc_n;
  logic [CNT_W-1:0] ret_n;
  logic [CNT_W-1:0] count_next;

  // The new destination is carried for completeness of the entry record
  // but nothing downstream of retirement consumes it yet.
  logic unused_p_rd;
  assign unused_p_rd = ^p_rd_q;

  // Stage p0: allocation / retirement decisions from registered state
  assign head1 = head + TAG_W'(1);
  assign tail1 = tail + TAG_W'(1);

  // Readiness deliberately ignores same-cycle retirement so it depends
  // only on registered count.
  assign alloc_ready = (count <= CNT_W'(DEPTH - 2));
  assign alloc_tag1  = tail;
  assign alloc_tag2  = tail1;
  assign rob_empty   = (count == '0);
  assign rob_full    = (count == CNT_W'(DEPTH));

  assign alloc1_ok = alloc_valid1 & alloc_ready;
  assign alloc2_ok = alloc1_ok & alloc_valid2;

  // Retirement looks only at registered done bits, so a writeback and the
  // retirement of the same entry always land on different edges.
  assign ret0 = valid_q[head] & done_q[head];
  assign ret1 = ret0 & valid_q[head1] & done_q[head1];

  assign alloc_n    = CNT_W'(alloc1_ok) + CNT_W'(alloc2_ok);
  assign ret_n      = CNT_W'(ret0) + CNT_W'(ret1);
  assign count_next = count + alloc_n - ret_n;

  // Stage p1: control state and registered retirement outputs
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      valid_q      <= '0;
      done_q       <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      free_reg1    <= '0;
      free_reg2    <= '0;
      retire_count <= '0;
    end else begin
      // Writeback to an entry that is not valid is dropped.
      for (int i = 0; i < NUM_FU; i++) begin
        if (wb_valid[i] && valid_q[wb_tag[i*TAG_W +: TAG_W]]) begin
          done_q[wb_tag[i*TAG_W +: TAG_W]] <= 1'b1;
        end
      end

      // Tail entries are guaranteed invalid whenever alloc_ready is high,
      // so allocation never collides with writeback or retirement.
      if (alloc1_ok) begin
        valid_q[tail] <= 1'b1;
        done_q[tail]  <= 1'b0;
      end
      if (alloc2_ok) begin
        valid_q[tail1] <= 1'b1;
        done_q[tail1]  <= 1'b0;
      end

      // Clearing comes last so it overrides a redundant writeback hit.
      if (ret0) begin
        valid_q[head] <= 1'b0;
        done_q[head]  <= 1'b0;
      end
      if (ret1) begin
        valid_q[head1] <= 1'b0;
        done_q[head1]  <= 1'b0;
      end

      head         <= head + ret_n[TAG_W-1:0];
      tail         <= tail + alloc_n[TAG_W-1:0];
      count        <= count_next;
      free_reg1    <= ret0 ? p_old_q[head]  : '0;
      free_reg2    <= ret1 ? p_old_q[head1] : '0;
      retire_count <= ret_n[1:0];
    end
  end

  // Stage p1: entry payload (no reset; qualified by the valid bits)
  always_ff @(posedge clk) begin
    if (alloc1_ok) begin
      p_rd_q[tail]  <= alloc1_p_rd;
      p_old_q[tail] <= alloc1_p_old_rd;
    end
    if (alloc2_ok) begin
      p_rd_q[tail1]  <= alloc2_p_rd;
      p_old_q[tail1] <= alloc2_p_old_rd;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer
//
// Directed scenarios followed by randomized traffic, all checked against a
// program-order queue model of the reorder buffer.
module tb_reorder_buffer;

  localparam int DEPTH  = 16;
  localparam int PREG_W = 6;
  localparam int NUM_FU = 3;
  localparam int TAG_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    alloc_valid1;
  logic                    alloc_valid2;
  logic [PREG_W-1:0]       alloc1_p_rd;
  logic [PREG_W-1:0]       alloc2_p_rd;
  logic [PREG_W-1:0]       alloc1_p_old_rd;
  logic [PREG_W-1:0]       alloc2_p_old_rd;
  logic                    alloc_ready;
  logic [TAG_W-1:0]        alloc_tag1;
  logic [TAG_W-1:0]        alloc_tag2;
  logic [NUM_FU-1:0]       wb_valid;
  logic [NUM_FU*TAG_W-1:0] wb_tag;
  logic                    flush;
  logic [PREG_W-1:0]       free_reg1;
  logic [PREG_W-1:0]       free_reg2;
  logic [1:0]              retire_count;
  logic                    rob_empty;
  logic                    rob_full;

  reorder_buffer #(
    .DEPTH(DEPTH), .PREG_W(PREG_W), .NUM_FU(NUM_FU), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid1(alloc_valid1), .alloc_valid2(alloc_valid2),
    .alloc1_p_rd(alloc1_p_rd), .alloc2_p_rd(alloc2_p_rd),
    .alloc1_p_old_rd(alloc1_p_old_rd), .alloc2_p_old_rd(alloc2_p_old_rd),
    .alloc_ready(alloc_ready), .alloc_tag1(alloc_tag1), .alloc_tag2(alloc_tag2),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .flush(flush),
    .free_reg1(free_reg1), .free_reg2(free_reg2), .retire_count(retire_count),
    .rob_empty(rob_empty), .rob_full(rob_full)
  );

  always #5 clk = ~clk;

  // Model: instructions in program order; element 0 is the oldest.
  int q_old[$];
  bit q_done[$];
  int mhead;
  int e_f1, e_f2, e_rc;
  int total = 0;
  int bad   = 0;

  function automatic int m_tail();
    return (mhead + q_old.size()) % DEPTH;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int sz, r, idx, t;
    if (!rst_n || flush) begin
      q_old.delete();
      q_done.delete();
      mhead = 0;
      e_f1 = 0; e_f2 = 0; e_rc = 0;
    end else begin
      sz = q_old.size();
      r = 0;
      if (sz > 0 && q_done[0]) r = 1;
      if (r == 1 && sz > 1 && q_done[1]) r = 2;
      for (int i = 0; i < NUM_FU; i++) begin
        if (wb_valid[i]) begin
          t = int'(wb_tag[i*TAG_W +: TAG_W]);
          idx = (t - mhead + DEPTH) % DEPTH;
          if (idx < sz) q_done[idx] = 1'b1;
        end
      end
      e_f1 = (r >= 1) ? q_old[0] : 0;
      e_f2 = (r == 2) ? q_old[1] : 0;
      e_rc = r;
      for (int k = 0; k < r; k++) begin
        void'(q_old.pop_front());
        void'(q_done.pop_front());
      end
      mhead = (mhead + r) % DEPTH;
      if (sz <= DEPTH - 2 && alloc_valid1) begin
        q_old.push_back(int'(alloc1_p_old_rd));
        q_done.push_back(1'b0);
        if (alloc_valid2) begin
          q_old.push_back(int'(alloc2_p_old_rd));
          q_done.push_back(1'b0);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("free_reg1", 32'(free_reg1), e_f1);
    chk("free_reg2", 32'(free_reg2), e_f2);
    chk("retire_count", 32'(retire_count), e_rc);
    chk("rob_empty", 32'(rob_empty), (q_old.size() == 0) ? 1 : 0);
    chk("rob_full", 32'(rob_full), (q_old.size() == DEPTH) ? 1 : 0);
    chk("alloc_ready", 32'(alloc_ready), (q_old.size() <= DEPTH - 2) ? 1 : 0);
    chk("alloc_tag1", 32'(alloc_tag1), m_tail());
    chk("alloc_tag2", 32'(alloc_tag2), (m_tail() + 1) % DEPTH);
  endtask

  task automatic set_idle();
    rst_n = 1'b1; flush = 1'b0;
    alloc_valid1 = 1'b0; alloc_valid2 = 1'b0;
    alloc1_p_rd = '0; alloc2_p_rd = '0;
    alloc1_p_old_rd = '0; alloc2_p_old_rd = '0;
    wb_valid = '0; wb_tag = '0;
  endtask

  task automatic set_alloc(bit v1, bit v2, int o1, int o2);
    alloc_valid1 = v1; alloc_valid2 = v2;
    alloc1_p_rd = PREG_W'($urandom_range(63, 1));
    alloc2_p_rd = PREG_W'($urandom_range(63, 1));
    alloc1_p_old_rd = PREG_W'(o1);
    alloc2_p_old_rd = PREG_W'(o2);
  endtask

  task automatic set_wb(logic [2:0] v, int t0, int t1, int t2);
    wb_valid = v;
    wb_tag = {TAG_W'(t2), TAG_W'(t1), TAG_W'(t0)};
  endtask

  task automatic do_reset();
    set_idle(); rst_n = 1'b0; tick(); set_idle();
  endtask

  initial begin
    int tt;
    // Reset state
    set_idle(); rst_n = 1'b0;
    tick(); tick();
    chk("rst_empty", 32'(rob_empty), 1);
    chk("rst_full", 32'(rob_full), 0);
    chk("rst_ready", 32'(alloc_ready), 1);
    chk("rst_tag1", 32'(alloc_tag1), 0);
    chk("rst_tag2", 32'(alloc_tag2), 1);
    chk("rst_rc", 32'(retire_count), 0);
    set_idle();

    // Pair allocate, pair writeback, pair retire
    set_alloc(1, 1, 5, 6); alloc1_p_rd = 6'd33; alloc2_p_rd = 6'd34;
    tick();
    chk("s1_tag_after_alloc", 32'(alloc_tag1), 2);
    set_idle(); set_wb(3'b011, 0, 1, 0);
    tick();
    chk("s1_no_early_retire", 32'(retire_count), 0);
    set_idle();
    tick();
    chk("s1_free1", 32'(free_reg1), 5);
    chk("s1_free2", 32'(free_reg2), 6);
    chk("s1_rc", 32'(retire_count), 2);
    chk("s1_empty", 32'(rob_empty), 1);

    // Out-of-order completion
    do_reset();
    set_alloc(1, 1, 7, 8); tick();
    set_alloc(1, 0, 9, 0); tick();
    set_idle(); set_wb(3'b001, 2, 0, 0); tick();
    set_idle(); set_wb(3'b010, 0, 1, 0); tick();
    chk("s2_wait_tag0_a", 32'(retire_count), 0);
    set_idle(); set_wb(3'b100, 0, 0, 0); tick();
    chk("s2_wait_tag0_b", 32'(retire_count), 0);
    set_idle(); tick();
    chk("s2_rc2", 32'(retire_count), 2);
    chk("s2_f1", 32'(free_reg1), 7);
    chk("s2_f2", 32'(free_reg2), 8);
    tick();
    chk("s2_rc1", 32'(retire_count), 1);
    chk("s2_f1b", 32'(free_reg1), 9);
    chk("s2_f2b", 32'(free_reg2), 0);

    // Fill to full, then a dropped extra allocation
    do_reset();
    for (int p = 0; p < 8; p++) begin
      set_alloc(1, 1, 20 + 2 * p, 21 + 2 * p);
      tick();
      if (p == 6) begin
        chk("s3_ready14", 32'(alloc_ready), 1);
        chk("s3_notfull14", 32'(rob_full), 0);
      end
    end
    chk("s3_full", 32'(rob_full), 1);
    chk("s3_not_ready", 32'(alloc_ready), 0);
    set_alloc(1, 1, 50, 51); tick();
    chk("s3_tail_held", 32'(alloc_tag1), 0);
    chk("s3_still_full", 32'(rob_full), 1);

    // Wrap-around with paired allocate / complete / retire
    do_reset();
    for (int k = 0; k < 20; k++) begin
      tt = m_tail();
      set_idle(); set_alloc(1, 1, $urandom_range(63, 1), $urandom_range(63, 1));
      tick();
      set_idle(); set_wb(3'b011, tt, (tt + 1) % DEPTH, 0);
      tick();
      chk("s4_count_le2", 32'(alloc_ready), 1);
    end
    set_idle(); tick(); tick();
    chk("s4_drained", 32'(rob_empty), 1);

    // Flush with 5 entries, 2 done
    do_reset();
    set_alloc(1, 1, 11, 12); tick();
    set_alloc(1, 1, 13, 14); tick();
    set_alloc(1, 0, 15, 0); tick();
    set_idle(); set_wb(3'b011, 2, 3, 0); tick();
    set_idle(); flush = 1'b1; set_alloc(1, 0, 30, 0); set_wb(3'b001, 0, 0, 0);
    tick();
    chk("s5_empty", 32'(rob_empty), 1);
    chk("s5_rc", 32'(retire_count), 0);
    chk("s5_f1", 32'(free_reg1), 0);
    set_idle(); set_wb(3'b001, 1, 0, 0); tick();
    chk("s5_stale_wb", 32'(rob_empty), 1);
    set_idle(); set_alloc(1, 0, 40, 0);
    chk("s5_tag0", 32'(alloc_tag1), 0);
    tick();
    set_idle(); tick();

    // Entry with nothing to free
    do_reset();
    set_alloc(1, 0, 0, 0); tick();
    set_idle(); set_wb(3'b001, 0, 0, 0); tick();
    set_idle(); tick();
    chk("s6_rc", 32'(retire_count), 1);
    chk("s6_f1", 32'(free_reg1), 0);

    // Reset mid-operation suppresses pending retirement
    set_alloc(1, 1, 21, 22); tick();
    set_idle(); set_wb(3'b011, 1, 2, 0); tick();
    set_idle(); rst_n = 1'b0; tick();
    chk("s7_rc", 32'(retire_count), 0);
    chk("s7_f1", 32'(free_reg1), 0);
    chk("s7_empty", 32'(rob_empty), 1);
    set_idle();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      set_idle();
      rst_n = ($urandom_range(199, 0) != 0);
      flush = ($urandom_range(49, 0) == 0);
      if (q_old.size() <= DEPTH - 2) begin
        set_alloc($urandom_range(2, 0) != 0, $urandom_range(1, 0) == 1,
                  $urandom_range(63, 0), $urandom_range(63, 0));
      end
      for (int i = 0; i < NUM_FU; i++) begin
        int t;
        if (q_old.size() > 0 && $urandom_range(3, 0) != 0)
          t = (mhead + int'($urandom_range(q_old.size() - 1, 0))) % DEPTH;
        else
          t = int'($urandom_range(DEPTH - 1, 0));
        wb_valid[i] = ($urandom_range(2, 0) == 0);
        wb_tag[i*TAG_W +: TAG_W] = TAG_W'(t);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
